// File: rtl/darkram_xarb_if.sv
// Bus bundle between the two requesters, the X-port arbiter and the darkram X port.
// The slave modport is the arbiter's view; master is the view from the requesters and darkram.
interface darkram_xarb_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  r0_req;
  logic                  r0_rd;
  logic                  r0_wr;
  logic [3:0]            r0_be;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [31:0]           r0_datai;
  logic [31:0]           r0_datao;
  logic                  r0_ack;
  logic                  r0_err;

  logic                  r1_req;
  logic                  r1_rd;
  logic                  r1_wr;
  logic [3:0]            r1_be;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [31:0]           r1_datai;
  logic [31:0]           r1_datao;
  logic                  r1_ack;
  logic                  r1_err;

  logic                  xdreq;
  logic                  xrd;
  logic                  xwr;
  logic [3:0]            xbe;
  logic [ADDR_WIDTH-1:0] xaddr;
  logic [31:0]           xatai;
  logic [31:0]           xatao;
  logic                  xdack;

  modport slave (
    input  r0_req, r0_rd, r0_wr, r0_be, r0_addr, r0_datai,
    output r0_datao, r0_ack, r0_err,
    input  r1_req, r1_rd, r1_wr, r1_be, r1_addr, r1_datai,
    output r1_datao, r1_ack, r1_err,
    output xdreq, xrd, xwr, xbe, xaddr, xatai,
    input  xatao, xdack
  );

  modport master (
    output r0_req, r0_rd, r0_wr, r0_be, r0_addr, r0_datai,
    input  r0_datao, r0_ack, r0_err,
    output r1_req, r1_rd, r1_wr, r1_be, r1_addr, r1_datai,
    input  r1_datao, r1_ack, r1_err,
    input  xdreq, xrd, xwr, xbe, xaddr, xatai,
    output xatao, xdack
  );
endinterface

// File: rtl/darkram_xarb.sv
// Two-requester round-robin arbiter/sequencer for the darkram X port, with a
// watchdog that forces completion (ERR, ERR_DATA) if XDACK never arrives.
module darkram_xarb #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          TMO_CYCLES = 255,
  parameter logic [31:0] ERR_DATA   = 32'hFFFF_FFFF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          hlt_i,
  output logic          gnt_o,
  darkram_xarb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  gnt_q, gnt_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  xdreq_q, xdreq_d;
  logic                  xrd_q, xrd_d;
  logic                  xwr_q, xwr_d;
  logic [3:0]            xbe_q, xbe_d;
  logic [ADDR_WIDTH-1:0] xaddr_q, xaddr_d;
  logic [31:0]           xatai_q, xatai_d;
  logic [31:0]           r0_datao_q, r0_datao_d;
  logic                  r0_ack_q, r0_ack_d;
  logic                  r0_err_q, r0_err_d;
  logic [31:0]           r1_datao_q, r1_datao_d;
  logic                  r1_ack_q, r1_ack_d;
  logic                  r1_err_q, r1_err_d;

  logic any_req;
  logic win;

  // On a tie the requester that did not win last time gets the grant.
  assign any_req = bus.r0_req | bus.r1_req;
  assign win     = (bus.r0_req & bus.r1_req) ? ~last_q : bus.r1_req;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    xdreq_d    = xdreq_q;
    xrd_d      = xrd_q;
    xwr_d      = xwr_q;
    xbe_d      = xbe_q;
    xaddr_d    = xaddr_q;
    xatai_d    = xatai_q;
    r0_datao_d = r0_datao_q;
    r1_datao_d = r1_datao_q;
    r0_ack_d   = 1'b0;
    r0_err_d   = 1'b0;
    r1_ack_d   = 1'b0;
    r1_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!hlt_i && any_req) begin
          state_d = BUSY;
          gnt_d   = win;
          last_d  = win;
          cnt_d   = 8'd0;
          xdreq_d = 1'b1;
          if (win) begin
            xrd_d   = bus.r1_rd;
            xwr_d   = bus.r1_wr;
            xbe_d   = bus.r1_be;
            xaddr_d = bus.r1_addr;
            xatai_d = bus.r1_datai;
          end else begin
            xrd_d   = bus.r0_rd;
            xwr_d   = bus.r0_wr;
            xbe_d   = bus.r0_be;
            xaddr_d = bus.r0_addr;
            xatai_d = bus.r0_datai;
          end
        end
      end
      BUSY: begin
        if (bus.xdack || cnt_q == TMO_LAST) begin
          state_d = DONE;
          xdreq_d = 1'b0;
          xrd_d   = 1'b0;
          xwr_d   = 1'b0;
          if (gnt_q) begin
            r1_datao_d = bus.xdack ? bus.xatao : ERR_DATA;
            r1_ack_d   = 1'b1;
            r1_err_d   = ~bus.xdack;
          end else begin
            r0_datao_d = bus.xdack ? bus.xatao : ERR_DATA;
            r0_ack_d   = 1'b1;
            r0_err_d   = ~bus.xdack;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any in-flight transfer without an ACK.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      cnt_q      <= 8'd0;
      xdreq_q    <= 1'b0;
      xrd_q      <= 1'b0;
      xwr_q      <= 1'b0;
      xbe_q      <= 4'd0;
      xaddr_q    <= '0;
      xatai_q    <= 32'd0;
      r0_datao_q <= 32'd0;
      r0_ack_q   <= 1'b0;
      r0_err_q   <= 1'b0;
      r1_datao_q <= 32'd0;
      r1_ack_q   <= 1'b0;
      r1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      xdreq_q    <= xdreq_d;
      xrd_q      <= xrd_d;
      xwr_q      <= xwr_d;
      xbe_q      <= xbe_d;
      xaddr_q    <= xaddr_d;
      xatai_q    <= xatai_d;
      r0_datao_q <= r0_datao_d;
      r0_ack_q   <= r0_ack_d;
      r0_err_q   <= r0_err_d;
      r1_datao_q <= r1_datao_d;
      r1_ack_q   <= r1_ack_d;
      r1_err_q   <= r1_err_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign bus.xdreq    = xdreq_q;
  assign bus.xrd      = xrd_q;
  assign bus.xwr      = xwr_q;
  assign bus.xbe      = xbe_q;
  assign bus.xaddr    = xaddr_q;
  assign bus.xatai    = xatai_q;
  assign bus.r0_datao = r0_datao_q;
  assign bus.r0_ack   = r0_ack_q;
  assign bus.r0_err   = r0_err_q;
  assign bus.r1_datao = r1_datao_q;
  assign bus.r1_ack   = r1_ack_q;
  assign bus.r1_err   = r1_err_q;

endmodule
